// File: rtl/ads4129_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ads4129_pkg
//  Description : Shared constants, sample-pair type and LVDS bit-pack helper
//                for the ADS4129 transmit emulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ads4129_pkg;

    localparam int SAMPLE_W = 12;
    localparam int WORD_W   = 24;
    localparam int GROUP_W  = 6;

    localparam logic [1:0] MODE_STREAM = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_FIXED  = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;

    localparam logic [SAMPLE_W-1:0] TOGGLE_A = 12'hAAA;
    localparam logic [SAMPLE_W-1:0] TOGGLE_B = 12'h555;

    typedef struct packed {
        logic [SAMPLE_W-1:0] s1;
        logic [SAMPLE_W-1:0] s0;
    } pair_t;

    // Even bits of each sample fill the low group, odd bits the high group.
    function automatic logic [WORD_W-1:0] pack_word(input logic [SAMPLE_W-1:0] s0,
                                                    input logic [SAMPLE_W-1:0] s1);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < GROUP_W; k++) begin
            w[k]             = s0[2*k];
            w[GROUP_W+k]     = s0[2*k+1];
            w[2*GROUP_W+k]   = s1[2*k];
            w[3*GROUP_W+k]   = s1[2*k+1];
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ads4129_lvds_tx_emu_if.sv
`default_nettype none
// ============================================================================
//  Interface   : ads4129_lvds_tx_emu_if
//  Description : Host sample-pair stream into the transmit emulator FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ads4129_lvds_tx_emu_if;
    import ads4129_pkg::*;

    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_sample_0;
    logic [SAMPLE_W-1:0] s_sample_1;

    modport master (output s_valid, output s_sample_0, output s_sample_1, input  s_ready);
    modport slave  (input  s_valid, input  s_sample_0, input  s_sample_1, output s_ready);

endinterface
`default_nettype wire

// File: rtl/ads4129_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ads4129_tx_fifo
//  Description : Synchronous FIFO for host sample pairs, full/empty from pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ads4129_tx_fifo #(
    parameter int P_DEPTH = 4,
    parameter int P_WIDTH = 24
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                i_push,
    input  wire [P_WIDTH-1:0]  i_data,
    input  wire                i_pop,
    output logic [P_WIDTH-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int C_AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [C_AW:0]      r_wr_ptr;
    logic [C_AW:0]      r_rd_ptr;
    logic               w_wr;
    logic               w_rd;

    // Extra pointer bit distinguishes a wrapped (full) FIFO from an empty one.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                     (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[C_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ads4129_lvds_tx_emu.sv
`default_nettype none
// ============================================================================
//  Module      : ads4129_lvds_tx_emu
//  Description : ADS4129 LVDS source emulator: stream/ramp/fixed/toggle samples
//                packed into the deserializer bit order. Define
//                ADS4129_TX_ODD_SKEW_EN to emulate the odd-channel capture offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ads4129_lvds_tx_emu
    import ads4129_pkg::*;
#(
    parameter int P_FIFO_DEPTH = 4
) (
    input  wire                       clk,
    input  wire                       rst_n,
    input  wire                       tx_en,
    input  wire  [1:0]                mode,
    input  wire  [SAMPLE_W-1:0]       fixed_pattern,
    ads4129_lvds_tx_emu_if.slave      s_if,
    output logic [WORD_W-1:0]         tx_bits,
    output logic                      tx_valid,
    output logic [15:0]               underflow_count
);

    logic [1:0]          r_mode;
    logic [SAMPLE_W-1:0] r_ramp_n;
    logic [15:0]         r_ucount;
    logic [WORD_W-1:0]   r_word;
    logic                r_valid;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    pair_t               w_fifo_rd;
    pair_t               w_fifo_wr;
    logic                w_push;
    logic                w_stream;
    logic                w_pop;
    logic                w_under;
    logic [SAMPLE_W-1:0] w_s0;
    logic [SAMPLE_W-1:0] w_s1;

    assign s_if.s_ready = !w_fifo_full;
    assign w_push       = s_if.s_valid && !w_fifo_full;
    assign w_fifo_wr    = '{s1: s_if.s_sample_1, s0: s_if.s_sample_0};
    assign w_stream     = (r_mode == MODE_STREAM);
    assign w_pop        = tx_en && w_stream && !w_fifo_empty;
    assign w_under      = tx_en && w_stream && w_fifo_empty;

    ads4129_tx_fifo #(
        .P_DEPTH (P_FIFO_DEPTH),
        .P_WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_fifo_wr),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_s0 = '0;
        w_s1 = '0;
        case (r_mode)
            MODE_STREAM: begin
                if (w_fifo_empty) begin
                    w_s0 = fixed_pattern;
                    w_s1 = fixed_pattern;
                end else begin
                    w_s0 = w_fifo_rd.s0;
                    w_s1 = w_fifo_rd.s1;
                end
            end
            MODE_RAMP: begin
                w_s0 = r_ramp_n;
                w_s1 = r_ramp_n + 12'd1;
            end
            MODE_FIXED: begin
                w_s0 = fixed_pattern;
                w_s1 = fixed_pattern;
            end
            default: begin
                w_s0 = TOGGLE_A;
                w_s1 = TOGGLE_B;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_STREAM;
            r_ramp_n <= '0;
            r_ucount <= '0;
            r_word   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_mode  <= mode;
            r_valid <= tx_en;
            r_word  <= tx_en ? pack_word(w_s0, w_s1) : '0;
            // Holding n at zero outside RAMP gives the clear-on-entry behaviour.
            if (r_mode != MODE_RAMP) begin
                r_ramp_n <= '0;
            end else if (tx_en) begin
                r_ramp_n <= r_ramp_n + 12'd2;
            end
            if (w_under && (r_ucount != 16'hFFFF)) begin
                r_ucount <= r_ucount + 16'd1;
            end
        end
    end

    assign underflow_count = r_ucount;

`ifdef ADS4129_TX_ODD_SKEW_EN
    logic [WORD_W-1:0] r_hold;
    logic [WORD_W-1:0] r_tx_bits;
    logic              r_tx_valid;

    // Low group of the current word rides with the upper 18 bits of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_tx_bits  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_hold     <= r_word;
            r_tx_valid <= r_valid;
            r_tx_bits  <= r_valid ? {r_word[GROUP_W-1:0], r_hold[WORD_W-1:GROUP_W]} : '0;
        end
    end

    assign tx_bits  = r_tx_bits;
    assign tx_valid = r_tx_valid;
`else
    assign tx_bits  = r_word;
    assign tx_valid = r_valid;
`endif

endmodule
`default_nettype wire
